// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider (seq_divider).
package seq_divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  // Widest dividend the shared counter and negate helper are sized for.
  localparam int unsigned MAX_WIDTH = 64;

  typedef logic [$clog2(MAX_WIDTH)-1:0] iter_cnt_t;

  function automatic logic [MAX_WIDTH-1:0] negate(input logic [MAX_WIDTH-1:0] value);
    return ~value + MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define SEQ_DIVIDER_DIV_ZERO_EN to add zero-divisor detection and the div_zero_o flag.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8,
  parameter bit SIGNED         = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
  input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
  input  logic                      data_valid_i,
  output logic                      ready_o,
  output logic [DIVIDEND_WIDTH-1:0] quotient_o,
  output logic [DIVISOR_WIDTH-1:0]  remainder_o,
  output logic                      data_valid_o,
  input  logic                      ready_i
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  ,
  output logic                      div_zero_o
`endif
);

  state_t                    state, next_state;
  logic [DIVIDEND_WIDTH-1:0] dividend_q;  // shifts out dividend bits, shifts in quotient bits
  logic [DIVISOR_WIDTH-1:0]  divisor_q;
  logic [DIVISOR_WIDTH:0]    partial;
  iter_cnt_t                 cnt;
  logic                      q_neg, r_neg;
  logic                      dvd_neg, dvs_neg;
  logic                      zero_div;
  logic [DIVISOR_WIDTH+1:0]  step_res;

  // One restoring step: returns {quotient_bit, next_partial_remainder}.
  function automatic logic [DIVISOR_WIDTH+1:0] div_step(
    input logic [DIVISOR_WIDTH:0]   part,
    input logic                     in_bit,
    input logic [DIVISOR_WIDTH-1:0] dvs
  );
    logic [DIVISOR_WIDTH+1:0] wide;
    wide = {part, in_bit};
    if (wide >= {2'b00, dvs}) begin
      return {1'b1, (DIVISOR_WIDTH+1)'(wide - {2'b00, dvs})};
    end
    return {1'b0, wide[DIVISOR_WIDTH:0]};
  endfunction

  assign dvd_neg  = SIGNED && dividend_q[DIVIDEND_WIDTH-1];
  assign dvs_neg  = SIGNED && divisor_q[DIVISOR_WIDTH-1];
  assign step_res = div_step(partial, dividend_q[DIVIDEND_WIDTH-1], divisor_q);

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  assign zero_div = (divisor_q == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    next_state   = state;
    ready_o      = 1'b0;
    data_valid_o = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (data_valid_i) next_state = PREP;
      end
      PREP:    next_state = zero_div ? DONE : CALC;
      CALC:    if (cnt == '0) next_state = FIX;
      FIX:     next_state = DONE;
      DONE: begin
        data_valid_o = 1'b1;
        if (ready_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      partial     <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      div_zero_o  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (data_valid_i) begin
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
          end
        end
        PREP: begin
          q_neg      <= dvd_neg ^ dvs_neg;
          r_neg      <= dvd_neg;
          dividend_q <= dvd_neg ? DIVIDEND_WIDTH'(negate(MAX_WIDTH'(dividend_q))) : dividend_q;
          divisor_q  <= dvs_neg ? DIVISOR_WIDTH'(negate(MAX_WIDTH'(divisor_q))) : divisor_q;
          partial    <= '0;
          cnt        <= iter_cnt_t'(DIVIDEND_WIDTH - 1);
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
          if (zero_div) begin
            quotient_o  <= '1;
            remainder_o <= dividend_q[DIVISOR_WIDTH-1:0];
            div_zero_o  <= 1'b1;
          end
`endif
        end
        CALC: begin
          dividend_q <= {dividend_q[DIVIDEND_WIDTH-2:0], step_res[DIVISOR_WIDTH+1]};
          partial    <= step_res[DIVISOR_WIDTH:0];
          cnt        <= cnt - iter_cnt_t'(1);
        end
        FIX: begin
          // Truncation toward zero: fix quotient sign by operand signs, remainder by dividend.
          quotient_o  <= q_neg ? DIVIDEND_WIDTH'(negate(MAX_WIDTH'(dividend_q))) : dividend_q;
          remainder_o <= r_neg ? DIVISOR_WIDTH'(negate(MAX_WIDTH'(partial[DIVISOR_WIDTH-1:0])))
                               : partial[DIVISOR_WIDTH-1:0];
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
          div_zero_o  <= 1'b0;
`endif
        end
        DONE: begin
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
          if (ready_i) div_zero_o <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: one unsigned and one signed instance (W=16, DW=8).
module tb_seq_divider;

  localparam int W   = 16;
  localparam int DW  = 8;
  localparam int LAT = W + 2;  // clock edges from accept edge to data_valid_o visible

  typedef struct {
    logic [W-1:0]  a;
    logic [DW-1:0] b;
    logic [W-1:0]  q;
    logic [DW-1:0] r;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  dividend [2];
  logic [DW-1:0] divisor  [2];
  logic          vin      [2];
  logic          rdy_out  [2];
  logic [W-1:0]  quo      [2];
  logic [DW-1:0] rem      [2];
  logic          vout     [2];
  logic          rdy_in   [2];
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  logic          dz       [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_divider #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(DW), .SIGNED(1'b0)) dut_u (
    .clk_i(clk), .rst_n_i(rst_n),
    .dividend_i(dividend[0]), .divisor_i(divisor[0]), .data_valid_i(vin[0]),
    .ready_o(rdy_out[0]), .quotient_o(quo[0]), .remainder_o(rem[0]),
    .data_valid_o(vout[0]), .ready_i(rdy_in[0])
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    , .div_zero_o(dz[0])
`endif
  );

  seq_divider #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(DW), .SIGNED(1'b1)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n),
    .dividend_i(dividend[1]), .divisor_i(divisor[1]), .data_valid_i(vin[1]),
    .ready_o(rdy_out[1]), .quotient_o(quo[1]), .remainder_o(rem[1]),
    .data_valid_o(vout[1]), .ready_i(rdy_in[1])
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    , .div_zero_o(dz[1])
`endif
  );

  // Present operands for one edge; afterwards scramble them to show only the accept edge counts.
  task automatic start_op(input int s, input logic [W-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    dividend[s] = a;
    divisor[s]  = b;
    vin[s]      = 1'b1;
    @(posedge clk);
    #1;
    vin[s]      = 1'b0;
    dividend[s] = ~a;
    divisor[s]  = ~b;
  endtask

  // Edges counted from the accept edge until data_valid_o is seen (capped at 100).
  task automatic wait_result(input int s, output int lat);
    lat = 0;
    while (!vout[s] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input int s);
    @(negedge clk);
    rdy_in[s] = 1'b1;
    @(posedge clk);
    #1;
    rdy_in[s] = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp += 4;
      if (rdy_out[s] !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b expected 1", s, rdy_out[s]); end
      if (vout[s] !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b expected 0", s, vout[s]); end
      if (quo[s] !== '0) begin n_bad++; $display("FAIL reset_quotient[%0d]: got %h expected 0", s, quo[s]); end
      if (rem[s] !== '0) begin n_bad++; $display("FAIL reset_remainder[%0d]: got %h expected 0", s, rem[s]); end
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      n_cmp++;
      if (dz[s] !== 1'b0) begin n_bad++; $display("FAIL reset_div_zero[%0d]: got %b expected 0", s, dz[s]); end
`endif
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int   lat;
    vec_t v[5];
    v[0] = '{16'd1000,  8'd7,   16'd142,   8'd6};
    v[1] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0};
    v[2] = '{16'd5,     8'd9,   16'd0,     8'd5};
    v[3] = '{16'hFFFF,  8'd255, 16'd257,   8'd0};
    v[4] = '{16'd0,     8'd3,   16'd0,     8'd0};
    for (int i = 0; i < 5; i++) begin
      start_op(0, v[i].a, v[i].b);
      wait_result(0, lat);
      n_cmp += 3;
      if (lat !== LAT) begin n_bad++; $display("FAIL u_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
      if (quo[0] !== v[i].q) begin n_bad++; $display("FAIL u_quotient[%0d]: got %h expected %h", i, quo[0], v[i].q); end
      if (rem[0] !== v[i].r) begin n_bad++; $display("FAIL u_remainder[%0d]: got %h expected %h", i, rem[0], v[i].r); end
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      n_cmp++;
      if (dz[0] !== 1'b0) begin n_bad++; $display("FAIL u_div_zero[%0d]: got %b expected 0", i, dz[0]); end
`endif
      consume(0);
      n_cmp += 2;
      if (rdy_out[0] !== 1'b1) begin n_bad++; $display("FAIL u_ready_after[%0d]: got %b expected 1", i, rdy_out[0]); end
      if (vout[0] !== 1'b0) begin n_bad++; $display("FAIL u_valid_after[%0d]: got %b expected 0", i, vout[0]); end
    end
  endtask

  task automatic test_signed();
    int   lat;
    vec_t v[5];
    v[0] = '{16'hFF9C, 8'd7,   16'hFFF2, 8'hFE};  // -100 / 7
    v[1] = '{16'h0064, 8'hF9,  16'hFFF2, 8'h02};  //  100 / -7
    v[2] = '{16'hFF9C, 8'hF9,  16'h000E, 8'hFE};  // -100 / -7
    v[3] = '{16'h8000, 8'hFF,  16'h8000, 8'h00};  // most-negative / -1 wraps
    v[4] = '{16'h0064, 8'd7,   16'h000E, 8'h02};  //  100 / 7
    for (int i = 0; i < 5; i++) begin
      start_op(1, v[i].a, v[i].b);
      wait_result(1, lat);
      n_cmp += 3;
      if (lat !== LAT) begin n_bad++; $display("FAIL s_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
      if (quo[1] !== v[i].q) begin n_bad++; $display("FAIL s_quotient[%0d]: got %h expected %h", i, quo[1], v[i].q); end
      if (rem[1] !== v[i].r) begin n_bad++; $display("FAIL s_remainder[%0d]: got %h expected %h", i, rem[1], v[i].r); end
      consume(1);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int late_valid;
    start_op(0, 16'd1000, 8'd7);
    wait_result(0, lat);
    n_cmp++;
    if (lat !== LAT) begin n_bad++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        dividend[0] = 16'd20;
        divisor[0]  = 8'd4;
        vin[0]      = 1'b1;
      end else begin
        vin[0] = 1'b0;
      end
      n_cmp += 4;
      if (vout[0] !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, vout[0]); end
      if (rdy_out[0] !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b expected 0", c, rdy_out[0]); end
      if (quo[0] !== 16'd142) begin n_bad++; $display("FAIL bp_quotient[%0d]: got %h expected %h", c, quo[0], 16'd142); end
      if (rem[0] !== 8'd6) begin n_bad++; $display("FAIL bp_remainder[%0d]: got %h expected %h", c, rem[0], 8'd6); end
    end
    @(negedge clk);
    vin[0] = 1'b0;
    consume(0);
    n_cmp++;
    if (rdy_out[0] !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after: got %b expected 1", rdy_out[0]); end
    late_valid = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (vout[0] !== 1'b0) late_valid++;
    end
    n_cmp++;
    if (late_valid !== 0) begin n_bad++; $display("FAIL bp_pulse_ignored: got %0d valid cycles expected 0", late_valid); end
    start_op(0, 16'd20, 8'd4);
    wait_result(0, lat);
    n_cmp += 2;
    if (quo[0] !== 16'd5) begin n_bad++; $display("FAIL bp_next_quotient: got %h expected %h", quo[0], 16'd5); end
    if (rem[0] !== 8'd0) begin n_bad++; $display("FAIL bp_next_remainder: got %h expected %h", rem[0], 8'd0); end
    consume(0);
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray;
    start_op(0, 16'd1000, 8'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (rdy_out[0] !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %b expected 1", rdy_out[0]); end
    if (vout[0] !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b expected 0", vout[0]); end
    if (quo[0] !== '0) begin n_bad++; $display("FAIL mid_reset_quotient: got %h expected 0", quo[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vout[0] !== 1'b0 || rdy_out[0] !== 1'b1) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin n_bad++; $display("FAIL mid_reset_idle: got %0d bad cycles expected 0", stray); end
    start_op(0, 16'd50, 8'd5);
    wait_result(0, lat);
    n_cmp += 3;
    if (lat !== LAT) begin n_bad++; $display("FAIL mid_reset_latency: got %0d expected %0d", lat, LAT); end
    if (quo[0] !== 16'd10) begin n_bad++; $display("FAIL mid_reset_quotient2: got %h expected %h", quo[0], 16'd10); end
    if (rem[0] !== 8'd0) begin n_bad++; $display("FAIL mid_reset_remainder2: got %h expected %h", rem[0], 8'd0); end
    consume(0);
  endtask

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
  task automatic test_div_zero();
    int lat;
    start_op(0, 16'd1234, 8'd0);
    wait_result(0, lat);
    n_cmp += 4;
    if (lat !== 1) begin n_bad++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    if (dz[0] !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b expected 1", dz[0]); end
    if (quo[0] !== 16'hFFFF) begin n_bad++; $display("FAIL dz_quotient: got %h expected ffff", quo[0]); end
    if (rem[0] !== 8'hD2) begin n_bad++; $display("FAIL dz_remainder: got %h expected d2", rem[0]); end
    consume(0);
    n_cmp++;
    if (dz[0] !== 1'b0) begin n_bad++; $display("FAIL dz_cleared: got %b expected 0", dz[0]); end
    start_op(0, 16'd10, 8'd3);
    wait_result(0, lat);
    n_cmp += 4;
    if (lat !== LAT) begin n_bad++; $display("FAIL dz_next_latency: got %0d expected %0d", lat, LAT); end
    if (dz[0] !== 1'b0) begin n_bad++; $display("FAIL dz_next_flag: got %b expected 0", dz[0]); end
    if (quo[0] !== 16'd3) begin n_bad++; $display("FAIL dz_next_quotient: got %h expected %h", quo[0], 16'd3); end
    if (rem[0] !== 8'd1) begin n_bad++; $display("FAIL dz_next_remainder: got %h expected %h", rem[0], 8'd1); end
    consume(0);
  endtask
`endif

  initial begin
    for (int s = 0; s < 2; s++) begin
      dividend[s] = '0;
      divisor[s]  = '0;
      vin[s]      = 1'b0;
      rdy_in[s]   = 1'b0;
    end
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid();
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    test_div_zero();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
